// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared types for the hazard/forwarding controller.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    // One in-flight instruction as seen by the hazard logic
    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       rf_en;
        logic       is_load;
    } hz_desc_t;

    // Forward select value meaning "take the operand from the register file"
    localparam int FWD_RF = 0;

    typedef enum logic {
        HZ_RUN   = 1'b0,
        HZ_FLUSH = 1'b1
    } hz_state_t;

    // x0 is hard-wired to zero, so a write to it never produces a value to forward
    function automatic logic is_writer(input hz_desc_t d);
        return d.valid & d.rf_en & (d.rd != 5'd0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/hz_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : hz_scoreboard
// Description : DEPTH-entry shift register of in-flight writer descriptors,
//               entry 0 = execute, entry DEPTH-1 = write-back.
// Revision    : 1.0 - initial release
// ============================================================================
module hz_scoreboard
    import pipe_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   bubble,
    input  hz_desc_t               din,
    output hz_desc_t [DEPTH-1:0]   entries
);

    // Advance the pipeline image one stage per cycle; a bubble replaces the decode slot
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            entries <= '0;
        end else begin
            entries[0] <= bubble ? hz_desc_t'('0) : din;
            for (int i = 1; i < DEPTH; i++) begin
                entries[i] <= entries[i-1];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Multi-stage forwarding select, load-use stall and redirect
//               flush controller with saturating stall/flush counters.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int DEPTH        = 2,
    parameter int LOAD_READY   = 1,
    parameter int ALU_READY    = 0,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       d_valid,
    input  logic [4:0]                 d_rs1,
    input  logic [4:0]                 d_rs2,
    input  logic                       d_rs1_used,
    input  logic                       d_rs2_used,
    input  logic [4:0]                 d_rd,
    input  logic                       d_rf_en,
    input  logic                       d_is_load,
    input  logic                       redirect,
    output logic [$clog2(DEPTH+1)-1:0] fwd_sela,
    output logic [$clog2(DEPTH+1)-1:0] fwd_selb,
    output logic                       stall,
    output logic                       flush,
    output logic [CNT_W-1:0]           stall_cnt,
    output logic [CNT_W-1:0]           flush_cnt
);

    localparam int              SEL_W   = $clog2(DEPTH+1);
    localparam logic [3:0]      RELOAD  = 4'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    hz_desc_t [DEPTH-1:0] entries;
    hz_desc_t             dec_desc;
    logic                 bubble;
    logic                 hold_a;
    logic                 hold_b;
    logic [SEL_W-1:0]     sel_a;
    logic [SEL_W-1:0]     sel_b;
    hz_state_t            state_q;
    hz_state_t            state_d;
    logic [3:0]           ctr_q;
    logic [3:0]           ctr_d;

    assign dec_desc = {d_valid, d_rd, d_rf_en, d_is_load};
    assign bubble   = flush | stall;

    hz_scoreboard #(
        .DEPTH   (DEPTH)
    ) u_scoreboard (
        .clk     (clk),
        .rst     (rst),
        .bubble  (bubble),
        .din     (dec_desc),
        .entries (entries)
    );

    // Youngest matching writer wins; {hold, sel} where hold means the winner
    // is too early in the pipe and an older match must not be used instead
    function automatic logic [SEL_W:0] resolve(input hz_desc_t [DEPTH-1:0] ent,
                                               input logic [4:0]           rs,
                                               input logic                 reads);
        logic             found;
        logic             win_load;
        int               win;
        logic             ready;
        logic [SEL_W-1:0] sel;
        logic             hold;
        found    = 1'b0;
        win_load = 1'b0;
        win      = 0;
        sel      = SEL_W'(FWD_RF);
        hold     = 1'b0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (is_writer(ent[k]) && (ent[k].rd == rs)) begin
                found    = 1'b1;
                win      = k;
                win_load = ent[k].is_load;
            end
        end
        if (reads && (rs != 5'd0) && found) begin
            ready = win_load ? (win >= LOAD_READY) : (win >= ALU_READY);
            if (ready) begin
                sel = SEL_W'(win + 1);
            end else begin
                hold = 1'b1;
            end
        end
        return {hold, sel};
    endfunction

    // Operand forwarding selects and load-use stall; a squashed decode never stalls
    always_comb begin
        {hold_a, sel_a} = resolve(entries, d_rs1, d_valid & d_rs1_used);
        {hold_b, sel_b} = resolve(entries, d_rs2, d_valid & d_rs2_used);
        fwd_sela        = sel_a;
        fwd_selb        = sel_b;
        stall           = (hold_a | hold_b) & ~flush;
    end

    // Redirect FSM state and flush countdown register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= HZ_RUN;
            ctr_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            ctr_q   <= ctr_d;
        end
    end

    // Redirect FSM next state; the redirect cycle itself is the first flush cycle
    always_comb begin
        state_d = state_q;
        ctr_d   = ctr_q;
        if (redirect) begin
            if (FLUSH_CYCLES > 1) begin
                state_d = HZ_FLUSH;
                ctr_d   = RELOAD;
            end else begin
                state_d = HZ_RUN;
                ctr_d   = 4'd0;
            end
        end else begin
            unique case (state_q)
                HZ_RUN: begin
                    state_d = HZ_RUN;
                end
                HZ_FLUSH: begin
                    if (ctr_q <= 4'd1) begin
                        state_d = HZ_RUN;
                        ctr_d   = 4'd0;
                    end else begin
                        ctr_d   = ctr_q - 4'd1;
                    end
                end
                default: begin
                    state_d = HZ_RUN;
                    ctr_d   = 4'd0;
                end
            endcase
        end
    end

    assign flush = redirect | (state_q == HZ_FLUSH);

    // Saturating performance counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && (stall_cnt != CNT_MAX)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (redirect && (flush_cnt != CNT_MAX)) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Table-driven self-checking bench for hazard_ctrl
//               (DEPTH=2, LOAD_READY=1, ALU_READY=0, FLUSH_CYCLES=2, CNT_W=3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

    localparam int DEPTH        = 2;
    localparam int LOAD_READY   = 1;
    localparam int ALU_READY    = 0;
    localparam int FLUSH_CYCLES = 2;
    localparam int CNT_W        = 3;
    localparam int SEL_W        = $clog2(DEPTH+1);

    typedef struct {
        int         id;
        logic       dv;
        logic [4:0] rs1;
        logic       u1;
        logic [4:0] rs2;
        logic       u2;
        logic [4:0] rd;
        logic       rf;
        logic       ld;
        logic       redir;
        int         sela;
        int         selb;
        int         stall;
        int         flush;
        int         sc;
        int         fc;
    } vec_t;

    logic             clk;
    logic             rst;
    logic             d_valid;
    logic [4:0]       d_rs1;
    logic [4:0]       d_rs2;
    logic             d_rs1_used;
    logic             d_rs2_used;
    logic [4:0]       d_rd;
    logic             d_rf_en;
    logic             d_is_load;
    logic             redirect;
    logic [SEL_W-1:0] fwd_sela;
    logic [SEL_W-1:0] fwd_selb;
    logic             stall;
    logic             flush;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    int   n_checks = 0;
    int   n_err    = 0;
    vec_t vecs[$];
    vec_t exp_q[$];
    int   next_id  = 0;

    hazard_ctrl #(
        .DEPTH        (DEPTH),
        .LOAD_READY   (LOAD_READY),
        .ALU_READY    (ALU_READY),
        .FLUSH_CYCLES (FLUSH_CYCLES),
        .CNT_W        (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .d_valid    (d_valid),
        .d_rs1      (d_rs1),
        .d_rs2      (d_rs2),
        .d_rs1_used (d_rs1_used),
        .d_rs2_used (d_rs2_used),
        .d_rd       (d_rd),
        .d_rf_en    (d_rf_en),
        .d_is_load  (d_is_load),
        .redirect   (redirect),
        .fwd_sela   (fwd_sela),
        .fwd_selb   (fwd_selb),
        .stall      (stall),
        .flush      (flush),
        .stall_cnt  (stall_cnt),
        .flush_cnt  (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic dv, input int rs1, input logic u1,
                                input int rs2, input logic u2, input int rd,
                                input logic rf, input logic ld, input logic redir,
                                input int sela, input int selb, input int st,
                                input int fl, input int sc, input int fc);
        vec_t v;
        v.id    = 0;
        v.dv    = dv;
        v.rs1   = 5'(rs1);
        v.u1    = u1;
        v.rs2   = 5'(rs2);
        v.u2    = u2;
        v.rd    = 5'(rd);
        v.rf    = rf;
        v.ld    = ld;
        v.redir = redir;
        v.sela  = sela;
        v.selb  = selb;
        v.stall = st;
        v.flush = fl;
        v.sc    = sc;
        v.fc    = fc;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        d_valid    = v.dv;
        d_rs1      = v.rs1;
        d_rs1_used = v.u1;
        d_rs2      = v.rs2;
        d_rs2_used = v.u2;
        d_rd       = v.rd;
        d_rf_en    = v.rf;
        d_is_load  = v.ld;
        redirect   = v.redir;
    endtask

    // Compare the oldest pending expectation against what the DUT shows now
    task automatic compare_front();
        vec_t e;
        if (exp_q.size() == 0) begin
            chk("scoreboard empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk($sformatf("row%0d fwd_sela", e.id),  32'(fwd_sela),  32'(e.sela));
            chk($sformatf("row%0d fwd_selb", e.id),  32'(fwd_selb),  32'(e.selb));
            chk($sformatf("row%0d stall", e.id),     32'(stall),     32'(e.stall));
            chk($sformatf("row%0d flush", e.id),     32'(flush),     32'(e.flush));
            chk($sformatf("row%0d stall_cnt", e.id), 32'(stall_cnt), 32'(e.sc));
            chk($sformatf("row%0d flush_cnt", e.id), 32'(flush_cnt), 32'(e.fc));
        end
    endtask

    // One decode cycle: drive after the edge, sample mid-cycle, commit on next edge
    task automatic step(input vec_t v);
        @(posedge clk);
        #1;
        v.id = next_id;
        next_id++;
        drive(v);
        exp_q.push_back(v);
        @(negedge clk);
        compare_front();
    endtask

    initial begin
        vec_t idle;
        vec_t rdr;
        idle = mk(0, 0,0, 0,0, 0,0,0,0, 0,0,0,0, 0,0);
        rst  = 1'b0;
        drive(idle);

        //          dv rs1 u1 rs2 u2 rd rf ld rd | sela selb st fl sc fc
        // forwarding from execute then write-back
        vecs.push_back(mk(0,  0, 0,  0, 0,  0, 0, 0, 0,  0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1,  0, 0,  0, 0,  5, 1, 0, 0,  0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1,  5, 1,  0, 0,  0, 0, 0, 0,  1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1,  5, 1,  0, 0,  0, 0, 0, 0,  2, 0, 0, 0, 0, 0));
        // load-use: one stall cycle, then forward from write-back
        vecs.push_back(mk(1,  0, 0,  0, 0,  6, 1, 1, 0,  0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1,  0, 0,  6, 1,  7, 1, 0, 0,  0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(1,  0, 0,  6, 1,  7, 1, 0, 0,  0, 2, 0, 0, 1, 0));
        // x0 writer ignored, youngest-wins, same register on both operands
        vecs.push_back(mk(1,  7, 1,  0, 0,  0, 1, 0, 0,  1, 0, 0, 0, 1, 0));
        vecs.push_back(mk(1,  0, 1,  0, 1,  7, 1, 0, 0,  0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(1,  7, 1,  7, 1,  7, 1, 0, 0,  1, 1, 0, 0, 1, 0));
        vecs.push_back(mk(1,  7, 1,  7, 0,  8, 0, 1, 0,  1, 0, 0, 0, 1, 0));
        vecs.push_back(mk(1,  8, 1,  7, 1,  0, 0, 0, 0,  0, 2, 0, 0, 1, 0));
        // redirect during a load-use stall: two flush cycles, no stall
        vecs.push_back(mk(1,  0, 0,  0, 0,  9, 1, 1, 0,  0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(1,  9, 1,  0, 0, 10, 1, 0, 1,  0, 0, 0, 1, 1, 0));
        vecs.push_back(mk(1,  9, 1,  0, 0, 10, 1, 0, 0,  2, 0, 0, 1, 1, 1));
        vecs.push_back(mk(0,  0, 0,  0, 0,  0, 0, 0, 0,  0, 0, 0, 0, 1, 1));
        // second redirect in flush cycle 2 extends flush to cycle 3
        vecs.push_back(mk(0,  0, 0,  0, 0,  0, 0, 0, 1,  0, 0, 0, 1, 1, 1));
        vecs.push_back(mk(0,  0, 0,  0, 0,  0, 0, 0, 1,  0, 0, 0, 1, 1, 2));
        vecs.push_back(mk(0,  0, 0,  0, 0,  0, 0, 0, 0,  0, 0, 0, 1, 1, 3));
        vecs.push_back(mk(0,  0, 0,  0, 0,  0, 0, 0, 0,  0, 0, 0, 0, 1, 3));
        // flush counter saturates at 7
        vecs.push_back(mk(0,  0, 0,  0, 0,  0, 0, 0, 1,  0, 0, 0, 1, 1, 3));
        vecs.push_back(mk(0,  0, 0,  0, 0,  0, 0, 0, 1,  0, 0, 0, 1, 1, 4));
        vecs.push_back(mk(0,  0, 0,  0, 0,  0, 0, 0, 1,  0, 0, 0, 1, 1, 5));
        vecs.push_back(mk(0,  0, 0,  0, 0,  0, 0, 0, 1,  0, 0, 0, 1, 1, 6));
        vecs.push_back(mk(0,  0, 0,  0, 0,  0, 0, 0, 1,  0, 0, 0, 1, 1, 7));
        vecs.push_back(mk(0,  0, 0,  0, 0,  0, 0, 0, 0,  0, 0, 0, 1, 1, 7));
        vecs.push_back(mk(0,  0, 0,  0, 0,  0, 0, 0, 0,  0, 0, 0, 0, 1, 7));
        // invalid decode slot never forwards
        vecs.push_back(mk(1,  0, 0,  0, 0, 11, 1, 0, 0,  0, 0, 0, 0, 1, 7));
        vecs.push_back(mk(0, 11, 1,  0, 0,  0, 0, 0, 0,  0, 0, 0, 0, 1, 7));
        // set up a pending load writer and enter FLUSH
        vecs.push_back(mk(1,  0, 0,  0, 0, 12, 1, 1, 0,  0, 0, 0, 0, 1, 7));
        vecs.push_back(mk(1, 12, 1,  0, 0,  0, 0, 0, 1,  0, 0, 0, 1, 1, 7));

        // reset state
        #3;
        chk("reset fwd_sela",  32'(fwd_sela),  32'd0);
        chk("reset fwd_selb",  32'(fwd_selb),  32'd0);
        chk("reset stall",     32'(stall),     32'd0);
        chk("reset flush",     32'(flush),     32'd0);
        chk("reset stall_cnt", 32'(stall_cnt), 32'd0);
        chk("reset flush_cnt", 32'(flush_cnt), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        foreach (vecs[i]) begin
            step(vecs[i]);
        end

        // mid-FLUSH with the load in write-back: reader forwards, then reset lands
        rdr = mk(1, 12, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        drive(rdr);
        @(negedge clk);
        chk("preflush flush",    32'(flush),    32'd1);
        chk("preflush fwd_sela", 32'(fwd_sela), 32'd2);
        chk("preflush stall",    32'(stall),    32'd0);
        #2;
        rst = 1'b0;
        #1;
        chk("async rst stall",     32'(stall),     32'd0);
        chk("async rst flush",     32'(flush),     32'd0);
        chk("async rst fwd_sela",  32'(fwd_sela),  32'd0);
        chk("async rst fwd_selb",  32'(fwd_selb),  32'd0);
        chk("async rst stall_cnt", 32'(stall_cnt), 32'd0);
        chk("async rst flush_cnt", 32'(flush_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("post rst fwd_sela", 32'(fwd_sela), 32'd0);
        chk("post rst flush",    32'(flush),    32'd0);
        chk("post rst stall",    32'(stall),    32'd0);

        // stall counter restarts from zero after reset
        step(mk(1,  0, 0,  0, 0, 13, 1, 1, 0,  0, 0, 0, 0, 0, 0));
        step(mk(1,  0, 0, 13, 1,  0, 0, 0, 0,  0, 0, 1, 0, 0, 0));
        step(mk(1,  0, 0, 13, 1,  0, 0, 0, 0,  0, 2, 0, 0, 1, 0));

        chk("scoreboard drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
